spi_cmd_controller: RTL and testbench
=====================================

# spi_cmd_controller

Command sequencer sitting between the SPI byte receiver and the BNN image buffer / inference core. Consumes received bytes via the receiver's valid/taken handshake, decodes a one-byte command set, streams image payload bytes into the image buffer write port, and launches inference and latches its result. It is the only owner of the receiver's `rx_enable`/`byte_taken` controls.

## Interface
- `IMG_BYTES`, 113: payload bytes per image (900 bits, packed MSB-first).
- `ADDR_W`, 7: image buffer byte-address width; must satisfy 2^ADDR_W ≥ IMG_BYTES.
- `TIMEOUT_CYCLES`, 10000: max clk cycles between payload bytes in LOAD.
- `clk  in  1`: system clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `byte_valid  in  1`: receiver holds a complete byte.
- `rx_data  in  8`: received byte, stable while `byte_valid`.
- `rx_enable  out  1`: permits the receiver to start a new byte.
- `byte_taken  out  1`: one-cycle pulse that consumes the held byte.
- `img_we  out  1`: image buffer write strobe.
- `img_addr  out  ADDR_W`: image buffer byte address.
- `img_wdata  out  8`: image buffer write data.
- `buf_clear  out  1`: one-cycle pulse that clears the image buffer.
- `infer_start  out  1`: one-cycle pulse that launches inference.
- `infer_done  in  1`: one-cycle pulse from the inference core.
- `infer_result  in  4`: class index, valid with `infer_done`.
- `result_valid  out  1`: latched result available.
- `result  out  4`: latched class index.
- `image_loaded  out  1`: complete image is present in the buffer.
- `err_cmd  out  1`: sticky; set by an unknown or illegal command.
- `err_timeout  out  1`: sticky; set by a LOAD timeout.

## Operation
- Reset values: all outputs 0; state is CMD; counters are 0; guard is 0.
- States:
  - CMD: waits for a command byte.
  - LOAD: receives payload bytes.
  - BUSY: inference running.
- `rx_enable` = 1 in CMD and LOAD; 0 in BUSY.
- Byte acceptance: a byte is accepted when `byte_valid`=1, guard=0, and state ≠ BUSY.
  - `byte_taken`=1 for exactly that cycle.
  - Guard is then loaded with 2, masking `byte_valid` for the next 2 cycles, because the receiver's `byte_valid` deasserts one cycle late.
- Opcodes in CMD:
  - 0x01 CLEAR: pulse `buf_clear`; clear `image_loaded`, `result_valid`, `err_cmd`, `err_timeout`.
  - 0x02 LOAD: byte counter ← 0; timeout counter ← 0; clear `image_loaded`; go to LOAD.
  - 0x03 START: if `image_loaded`, pulse `infer_start`, clear `result_valid`, go to BUSY; otherwise set `err_cmd` and stay in CMD.
  - Any other value: set `err_cmd`; stay in CMD.
- LOAD, per accepted byte:
  - Next cycle: `img_we`=1, `img_addr`=byte count, `img_wdata`=byte.
  - Count increments by 1; timeout counter resets.
  - On the byte with count = IMG_BYTES-1: set `image_loaded` and go to CMD in the same cycle as `img_we`.
  - Bytes in LOAD are never decoded as commands.
- LOAD timeout: when the timeout counter reaches TIMEOUT_CYCLES-1 with no byte accepted, go to CMD, set `err_timeout`, and leave `image_loaded`=0. A byte accepted in that same cycle wins; there is no timeout.
- BUSY: on `infer_done`, latch `result` ← `infer_result`, set `result_valid`, clear `image_loaded` (one inference per load), go to CMD. A `byte_valid` in BUSY is held and not taken; it is consumed after the return to CMD.
- An `infer_done` outside BUSY is ignored.
- Reset mid-operation: everything returns to reset values immediately; the partial image is discarded (`image_loaded`=0).

## Timing
- Byte accepted at cycle N: `byte_taken` at N.
  - In LOAD: `img_we` at N+1.
  - CLEAR: `buf_clear` at N+1.
  - START: `infer_start` at N+1.
- State changes take effect at N+1.
- Earliest next acceptance is N+3 (guard).
- `infer_done` at cycle M: `result_valid`/`result` at M+1; CMD state at M+1.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted LOAD byte (or after the LOAD opcode).
- Counters:
  - Byte count is ADDR_W bits and never wraps (exit at IMG_BYTES-1).
  - Timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates.

## Structure
- Shared package `spi_ctrl_pkg`: opcode localparams (CMD_CLEAR, CMD_LOAD, CMD_START), the `ctrl_state_t` enum {CMD, LOAD, BUSY}, the IMG_BYTES default, and the result width (4).
- One natural sub-module: `spi_timeout_timer` (clear, enable, expired), reusable for the receiver's idle timeout.

## Test plan
- Reset then LOAD with 113 bytes 0x00..0x70 → 113 `img_we` pulses, addr 0..112 with data = addr; `image_loaded`=1 after the last write; exactly 113+1 `byte_taken` pulses.
- START before any load → `err_cmd`=1, no `infer_start`. CLEAR → `err_cmd`=0, one `buf_clear` pulse.
- Full load, START, `infer_done` with result 7 after 50 cycles → `infer_start` 1 cycle after take; `rx_enable`=0 during BUSY; `result`=7 and `result_valid`=1 the cycle after done; `image_loaded`=0.
- LOAD, 10 bytes, then silence → `err_timeout`=1 exactly TIMEOUT_CYCLES after the 10th byte; state CMD; `image_loaded`=0. Boundary: a byte arriving on the expiry cycle is written and no error is raised.
- `byte_valid` held high for 3 cycles per byte (receiver lag) → exactly one `byte_taken` per byte. Opcode 0xFF → `err_cmd`; the following LOAD still works.
- Assert `rst_n` mid-LOAD at byte 50 → all outputs 0 immediately; a fresh LOAD restarts at addr 0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command controller: opcodes, state encoding
// and image/result sizing.
package spi_ctrl_pkg;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LOAD  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;

  localparam int IMG_BYTES_DEFAULT = 113;
  localparam int RESULT_W          = 4;

  typedef enum logic [1:0] {
    CMD,
    LOAD,
    BUSY
  } ctrl_state_t;

endpackage

// File: rtl/spi_timeout_timer.sv
// Saturating inactivity timer: counts enabled cycles since the last clear and
// flags expiry while the count sits at CYCLES-1.
module spi_timeout_timer #(
  parameter int CYCLES = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == LAST);

endmodule

// File: rtl/spi_cmd_controller.sv
// Command sequencer between the SPI byte receiver and the BNN image buffer /
// inference core: decodes commands, streams payload, launches inference.
module spi_cmd_controller
  import spi_ctrl_pkg::*;
#(
  parameter int IMG_BYTES      = IMG_BYTES_DEFAULT,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                byte_valid,
  input  logic [7:0]          rx_data,
  output logic                rx_enable,
  output logic                byte_taken,
  output logic                img_we,
  output logic [ADDR_W-1:0]   img_addr,
  output logic [7:0]          img_wdata,
  output logic                buf_clear,
  output logic                infer_start,
  input  logic                infer_done,
  input  logic [RESULT_W-1:0] infer_result,
  output logic                result_valid,
  output logic [RESULT_W-1:0] result,
  output logic                image_loaded,
  output logic                err_cmd,
  output logic                err_timeout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

  ctrl_state_t       state;
  logic [1:0]        guard;
  logic [ADDR_W-1:0] byte_cnt;
  logic              accept;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;

  // rx_enable is low in BUSY and during the first cycle out of reset, so it
  // doubles as the "not busy" qualifier for acceptance.
  assign accept     = byte_valid && (guard == 2'd0) && rx_enable;
  assign byte_taken = accept;

  assign timer_enable = (state == LOAD);
  assign timer_clear  = accept || (state != LOAD);

  spi_timeout_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= CMD;
      guard        <= 2'd0;
      byte_cnt     <= '0;
      rx_enable    <= 1'b0;
      img_we       <= 1'b0;
      img_addr     <= '0;
      img_wdata    <= 8'h00;
      buf_clear    <= 1'b0;
      infer_start  <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      image_loaded <= 1'b0;
      err_cmd      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      img_we      <= 1'b0;
      buf_clear   <= 1'b0;
      infer_start <= 1'b0;
      rx_enable   <= (state != BUSY);

      // The receiver drops byte_valid a cycle late; mask it for two cycles.
      if (accept) begin
        guard <= 2'd2;
      end else if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end

      case (state)
        CMD: begin
          if (accept) begin
            case (rx_data)
              CMD_CLEAR: begin
                buf_clear    <= 1'b1;
                image_loaded <= 1'b0;
                result_valid <= 1'b0;
                err_cmd      <= 1'b0;
                err_timeout  <= 1'b0;
              end
              CMD_LOAD: begin
                byte_cnt     <= '0;
                image_loaded <= 1'b0;
                state        <= LOAD;
              end
              CMD_START: begin
                if (image_loaded) begin
                  infer_start  <= 1'b1;
                  result_valid <= 1'b0;
                  rx_enable    <= 1'b0;
                  state        <= BUSY;
                end else begin
                  err_cmd <= 1'b1;
                end
              end
              default: err_cmd <= 1'b1;
            endcase
          end
        end
        LOAD: begin
          // An accepted byte beats a timeout expiring in the same cycle.
          if (accept) begin
            img_we    <= 1'b1;
            img_addr  <= byte_cnt;
            img_wdata <= rx_data;
            if (byte_cnt == LAST_ADDR) begin
              image_loaded <= 1'b1;
              state        <= CMD;
            end else begin
              byte_cnt <= byte_cnt + ADDR_W'(1);
            end
          end else if (timer_expired) begin
            err_timeout  <= 1'b1;
            image_loaded <= 1'b0;
            state        <= CMD;
          end
        end
        BUSY: begin
          if (infer_done) begin
            result       <= infer_result;
            result_valid <= 1'b1;
            image_loaded <= 1'b0;
            rx_enable    <= 1'b1;
            state        <= CMD;
          end
        end
        default: state <= CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Scoreboard bench for spi_cmd_controller: expected image writes are queued as
// payload is driven and popped by a monitor on every img_we.
module tb_spi_cmd_controller;
  import spi_ctrl_pkg::*;

  localparam int IMG_BYTES = 113;
  localparam int ADDR_W    = 7;
  localparam int T_CYC     = 10000;

  logic              clk;
  logic              rst_n;
  logic              byte_valid;
  logic [7:0]        rx_data;
  logic              rx_enable;
  logic              byte_taken;
  logic              img_we;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_wdata;
  logic              buf_clear;
  logic              infer_start;
  logic              infer_done;
  logic [3:0]        infer_result;
  logic              result_valid;
  logic [3:0]        result;
  logic              image_loaded;
  logic              err_cmd;
  logic              err_timeout;

  spi_cmd_controller #(
    .IMG_BYTES      (IMG_BYTES),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (T_CYC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_valid   (byte_valid),
    .rx_data      (rx_data),
    .rx_enable    (rx_enable),
    .byte_taken   (byte_taken),
    .img_we       (img_we),
    .img_addr     (img_addr),
    .img_wdata    (img_wdata),
    .buf_clear    (buf_clear),
    .infer_start  (infer_start),
    .infer_done   (infer_done),
    .infer_result (infer_result),
    .result_valid (result_valid),
    .result       (result),
    .image_loaded (image_loaded),
    .err_cmd      (err_cmd),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard entries are {addr, data}.
  logic [14:0] exp_q[$];
  int taken_cnt = 0, we_cnt = 0, clear_cnt = 0, start_cnt = 0;
  int taken_cyc = 0, clear_cyc = 0, start_cyc = 0;

  always @(negedge clk) begin
    if (img_we) begin
      we_cnt++;
      check("we_latency", cyc, taken_cyc + 1);
      if (exp_q.size() == 0) begin
        check("we_unexpected", {31'd0, img_we}, 32'd0);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("img_addr", {25'd0, img_addr}, {25'd0, e[14:8]});
        check("img_wdata", {24'd0, img_wdata}, {24'd0, e[7:0]});
        check("loaded_at_last", {31'd0, image_loaded}, {31'd0, (e[14:8] == 7'(IMG_BYTES - 1))});
      end
    end
    if (buf_clear)   begin clear_cnt++; clear_cyc = cyc; end
    if (infer_start) begin start_cnt++; start_cyc = cyc; end
    if (byte_taken)  begin taken_cnt++; taken_cyc = cyc; end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Models the receiver: byte_valid stays high 3 cycles per byte.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    int tc = 0;
    byte_valid = 1'b1;
    rx_data    = b;
    forever begin
      @(negedge clk);
      if (byte_taken) begin
        tc = cyc;
        break;
      end
      waited++;
      if (waited > 200) begin
        check("take_timeout", {31'd0, byte_taken}, 32'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    wait_cycles(3);
    byte_valid = 1'b0;
    $display("byte 0x%02h taken at cycle %0d", b, tc);
  endtask

  task automatic push_and_send(input int addr, input logic [7:0] b);
    exp_q.push_back({7'(addr), b});
    send_byte(b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_enable"},    {31'd0, rx_enable},    32'd0);
    check({tag, "_byte_taken"},   {31'd0, byte_taken},   32'd0);
    check({tag, "_img_we"},       {31'd0, img_we},       32'd0);
    check({tag, "_img_addr"},     {25'd0, img_addr},     32'd0);
    check({tag, "_img_wdata"},    {24'd0, img_wdata},    32'd0);
    check({tag, "_buf_clear"},    {31'd0, buf_clear},    32'd0);
    check({tag, "_infer_start"},  {31'd0, infer_start},  32'd0);
    check({tag, "_result_valid"}, {31'd0, result_valid}, 32'd0);
    check({tag, "_result"},       {28'd0, result},       32'd0);
    check({tag, "_image_loaded"}, {31'd0, image_loaded}, 32'd0);
    check({tag, "_err_cmd"},      {31'd0, err_cmd},      32'd0);
    check({tag, "_err_timeout"},  {31'd0, err_timeout},  32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bt;
    rst_n        = 1'b0;
    byte_valid   = 1'b0;
    rx_data      = 8'h00;
    infer_done   = 1'b0;
    infer_result = 4'h0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);
    check("rx_enable_after_reset", {31'd0, rx_enable}, 32'd1);

    // START with no image, then CLEAR
    send_byte(CMD_START);
    check("start_unloaded_err", {31'd0, err_cmd}, 32'd1);
    check("start_unloaded_no_pulse", start_cnt, 32'd0);
    send_byte(CMD_CLEAR);
    check("clear_err_cmd", {31'd0, err_cmd}, 32'd0);
    check("clear_pulses", clear_cnt, 32'd1);
    check("clear_latency", clear_cyc, taken_cyc + 1);

    // Full image load
    taken_cnt = 0;
    we_cnt    = 0;
    send_byte(CMD_LOAD);
    for (int i = 0; i < IMG_BYTES; i++) push_and_send(i, 8'(i));
    check("load_we_count", we_cnt, IMG_BYTES);
    check("load_taken_count", taken_cnt, IMG_BYTES + 1);
    check("load_image_loaded", {31'd0, image_loaded}, 32'd1);
    check("load_q_empty", exp_q.size(), 32'd0);

    // START, hold a byte during BUSY, finish with result 7
    send_byte(CMD_START);
    check("start_pulses", start_cnt, 32'd1);
    check("start_latency", start_cyc, taken_cyc + 1);
    check("busy_rx_enable", {31'd0, rx_enable}, 32'd0);
    bt         = taken_cnt;
    byte_valid = 1'b1;
    rx_data    = 8'h05;
    wait_cycles(46);
    check("busy_rx_enable_late", {31'd0, rx_enable}, 32'd0);
    check("busy_no_take", taken_cnt, bt);
    infer_done   = 1'b1;
    infer_result = 4'd7;
    check("result_valid_before_done", {31'd0, result_valid}, 32'd0);
    wait_cycles(1);
    infer_done   = 1'b0;
    infer_result = 4'd0;
    check("done_result_valid", {31'd0, result_valid}, 32'd1);
    check("done_result", {28'd0, result}, 32'd7);
    check("done_image_loaded", {31'd0, image_loaded}, 32'd0);
    check("done_rx_enable", {31'd0, rx_enable}, 32'd1);
    check("held_byte_taken", {31'd0, byte_taken}, 32'd1);
    wait_cycles(2);
    byte_valid = 1'b0;
    check("held_byte_err_cmd", {31'd0, err_cmd}, 32'd1);
    infer_done   = 1'b1;
    infer_result = 4'd3;
    wait_cycles(1);
    infer_done   = 1'b0;
    wait_cycles(1);
    check("stray_done_result", {28'd0, result}, 32'd7);
    check("stray_done_valid", {31'd0, result_valid}, 32'd1);
    send_byte(CMD_CLEAR);
    check("clear_result_valid", {31'd0, result_valid}, 32'd0);
    check("clear_err_cmd2", {31'd0, err_cmd}, 32'd0);

    // LOAD timeout after 10 bytes
    send_byte(CMD_LOAD);
    for (int i = 0; i < 10; i++) push_and_send(i, 8'(8'h80 + i));
    n = taken_cyc;
    wait_until(n + T_CYC);
    check("timeout_not_yet", {31'd0, err_timeout}, 32'd0);
    wait_cycles(1);
    check("timeout_fired", {31'd0, err_timeout}, 32'd1);
    check("timeout_image_loaded", {31'd0, image_loaded}, 32'd0);
    bt = start_cnt;
    send_byte(CMD_START);
    check("timeout_back_in_cmd", {31'd0, err_cmd}, 32'd1);
    check("timeout_no_start", start_cnt, bt);
    send_byte(CMD_CLEAR);
    check("clear_err_timeout", {31'd0, err_timeout}, 32'd0);

    // Byte arriving on the expiry cycle wins
    send_byte(CMD_LOAD);
    for (int i = 0; i < 10; i++) push_and_send(i, 8'(8'h40 + i));
    n = taken_cyc;
    wait_until(n + T_CYC);
    exp_q.push_back({7'd10, 8'hAB});
    byte_valid = 1'b1;
    rx_data    = 8'hAB;
    @(negedge clk);
    check("boundary_take", {31'd0, byte_taken}, 32'd1);
    wait_cycles(1);
    check("boundary_no_err", {31'd0, err_timeout}, 32'd0);
    wait_cycles(1);
    byte_valid = 1'b0;
    wait_cycles(3);
    check("boundary_no_err_late", {31'd0, err_timeout}, 32'd0);
    bt = start_cnt;
    push_and_send(11, CMD_START);
    check("boundary_still_load", start_cnt, bt);
    check("boundary_no_err_cmd", {31'd0, err_cmd}, 32'd0);

    // Abandon that load, then bad opcode followed by LOAD and mid-load reset
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);
    taken_cnt = 0;
    send_byte(8'hFF);
    check("bad_opcode_err", {31'd0, err_cmd}, 32'd1);
    send_byte(CMD_LOAD);
    for (int i = 0; i < 50; i++) push_and_send(i, 8'(i) ^ 8'h5A);
    check("lag_one_take_per_byte", taken_cnt, 32'd52);
    check("partial_not_loaded", {31'd0, image_loaded}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midload_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cycles(2);
    send_byte(CMD_LOAD);
    for (int i = 0; i < 3; i++) push_and_send(i, 8'(8'hE0 + i));
    check("restart_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
